// File: rtl/reg_file16.sv
// 16-entry x 16-bit register file: two combinational read ports with same-cycle
// write bypass, a primary write port and a dedicated R0 write port.
`timescale 1ns/1ps

module reg_file16 #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en_r0,
    input  logic [DATA_W-1:0] wr_data_r0
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    // R0 port is applied last so it wins a same-address collision.
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wr_addr] = wr_data;
        end
        if (wr_en_r0) begin
            regs_d[0] = wr_data_r0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reading the next-state array gives the bypass with the required priority.
    always_comb begin
        rd_data1 = '0;
        rd_data2 = '0;
        if (rst_n) begin
            rd_data1 = regs_d[rd_addr1];
            rd_data2 = regs_d[rd_addr2];
        end
    end

endmodule
